// File: rtl/ooo_mem_resp.sv
// Tagged out-of-order memory responder: each request waits addr[5:2] cycles in a
// slot, then returns {id, addr ^ KEY} through a single output register.
module ooo_mem_resp #(
  parameter int                NUM_SLOT = 4,
  parameter int                IDW      = 4,
  parameter int                AW       = 32,
  parameter logic [AW-1:0]     KEY      = AW'(32'hA5A5_0000)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [IDW-1:0]                  req_id,
  input  logic [AW-1:0]                   req_addr,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [IDW-1:0]                  rsp_id,
  output logic [AW-1:0]                   rsp_data,
  output logic [$clog2(NUM_SLOT+1)-1:0]   occ_o
);

  localparam int SW  = (NUM_SLOT > 1) ? $clog2(NUM_SLOT) : 1;
  localparam int OCW = $clog2(NUM_SLOT+1);

  logic [NUM_SLOT-1:0] slot_vld;
  logic [IDW-1:0]      slot_id   [NUM_SLOT];
  logic [AW-1:0]       slot_addr [NUM_SLOT];
  logic [3:0]          slot_cnt  [NUM_SLOT];

  logic                out_vld;
  logic [IDW-1:0]      out_id;
  logic [AW-1:0]       out_data;

  logic                free_found;
  logic [SW-1:0]       free_idx;
  logic                elig_found;
  logic [SW-1:0]       elig_idx;
  logic [OCW-1:0]      occ;
  logic                accept;
  logic                load;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    elig_found = 1'b0;
    elig_idx   = '0;
    occ        = '0;
    // Walk downwards so the lowest index wins for both free and eligible picks.
    for (int i = NUM_SLOT - 1; i >= 0; i--) begin
      if (!slot_vld[i]) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
      if (slot_vld[i] && (slot_cnt[i] == 4'd0)) begin
        elig_found = 1'b1;
        elig_idx   = SW'(i);
      end
      occ = occ + OCW'(slot_vld[i]);
    end
  end

  assign req_ready = free_found;
  assign accept    = req_valid && req_ready;
  // The output register only moves when empty or being drained, so a pending
  // response is never replaced by a newly eligible slot.
  assign load      = (!out_vld || rsp_ready) && elig_found;

  // NOTE: the slot payload is reset along with vld; it is only a few flops and
  // keeps the state fully defined after reset for FPGA bring-up.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      slot_vld <= '0;
      for (int i = 0; i < NUM_SLOT; i++) begin
        slot_id[i]   <= '0;
        slot_addr[i] <= '0;
        slot_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOT; i++) begin
        if (load && (elig_idx == SW'(i))) begin
          slot_vld[i] <= 1'b0;
        end else if (accept && (free_idx == SW'(i))) begin
          // NOTE: sequential state uses non-blocking assignments so every
          // register samples the pre-edge values, independent of statement order.
          slot_vld[i]  <= 1'b1;
          slot_id[i]   <= req_id;
          slot_addr[i] <= req_addr;
          slot_cnt[i]  <= req_addr[5:2];
        end else if (slot_vld[i] && (slot_cnt[i] != 4'd0)) begin
          slot_cnt[i] <= slot_cnt[i] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_vld  <= 1'b0;
      out_id   <= '0;
      out_data <= '0;
    end else if (load) begin
      out_vld  <= 1'b1;
      out_id   <= slot_id[elig_idx];
      out_data <= slot_addr[elig_idx] ^ KEY;
    end else if (rsp_ready) begin
      out_vld  <= 1'b0;
    end
  end

  assign rsp_valid = out_vld;
  assign rsp_id    = out_id;
  assign rsp_data  = out_data;
  assign occ_o     = occ;

endmodule

// File: tb/tb_ooo_mem_resp.sv
// Self-checking bench for ooo_mem_resp: directed scenarios with literal
// expectations plus a per-cycle comparison against a due-time request model.
module tb_ooo_mem_resp;

  localparam int          NS  = 4;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_id;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  rsp_id;
  logic [31:0] rsp_data;
  logic [2:0]  occ_o;

  ooo_mem_resp #(.NUM_SLOT(NS), .IDW(4), .AW(32), .KEY(KEY)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_id    (req_id),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .occ_o     (occ_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Model: outstanding requests with the cycle they become eligible and the
  // slot index they occupy (lowest free slot at accept time).
  typedef struct {
    int          slot;
    logic [3:0]  id;
    logic [31:0] addr;
    int          due;
  } ent_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
  } rsp_t;

  ent_t        mq[$];
  rsp_t        sb[$];
  bit          m_out_vld = 1'b0;
  logic [3:0]  m_out_id  = '0;
  logic [31:0] m_out_data = '0;

  task automatic model_step();
    int   sel = -1;
    int   fs  = -1;
    bit   acc;
    ent_t ne;
    logic [NS-1:0] busy = '0;
    foreach (mq[i]) busy[mq[i].slot] = 1'b1;
    foreach (mq[i])
      if (mq[i].due <= cyc && (sel < 0 || mq[i].slot < mq[sel].slot)) sel = i;
    acc = req_valid && (mq.size() < NS);
    if (acc) begin
      for (int s = NS - 1; s >= 0; s--) if (!busy[s]) fs = s;
      ne.slot = fs;
      ne.id   = req_id;
      ne.addr = req_addr;
      ne.due  = cyc + int'(req_addr[5:2]) + 1;
      sb.push_back('{id: req_id, data: req_addr ^ KEY});
    end
    if ((!m_out_vld || rsp_ready) && sel >= 0) begin
      m_out_vld  = 1'b1;
      m_out_id   = mq[sel].id;
      m_out_data = mq[sel].addr ^ KEY;
      mq.delete(sel);
    end else if (rsp_ready) begin
      m_out_vld = 1'b0;
    end
    if (acc) mq.push_back(ne);
  endtask

  always @(posedge clk) begin
    if (rstn) model_step();
    cyc++;
  end

  always @(negedge rstn) begin
    mq.delete();
    sb.delete();
    m_out_vld = 1'b0;
  end

  // Per-cycle comparison, sampled just after the falling edge.
  bit          prev_stall = 1'b0;
  logic [3:0]  prev_id;
  logic [31:0] prev_data;

  always @(negedge clk) begin
    #1;
    check("req_ready", req_ready, mq.size() < NS);
    check("occ", occ_o, mq.size());
    check("rsp_valid", rsp_valid, m_out_vld);
    if (m_out_vld) begin
      check("rsp_id", rsp_id, m_out_id);
      check("rsp_data", rsp_data, m_out_data);
    end
    if (rstn && prev_stall) begin
      check("stall_valid", rsp_valid, 1'b1);
      check("stall_data", {rsp_id, rsp_data}, {prev_id, prev_data});
    end
    if (rstn && rsp_valid && rsp_ready) begin
      int hit = -1;
      foreach (sb[i])
        if (hit < 0 && sb[i].id == rsp_id && sb[i].data == rsp_data) hit = i;
      check("sb_match", hit >= 0, 1'b1);
      if (hit >= 0) sb.delete(hit);
    end
    prev_stall = rstn && rsp_valid && !rsp_ready;
    prev_id    = rsp_id;
    prev_data  = rsp_data;
  end

  // Called at a falling edge; returns the cycle in which the handshake happened.
  task automatic send(input logic [3:0] id, input logic [31:0] addr, output int t);
    int n = 0;
    req_valid = 1'b1;
    req_id    = id;
    req_addr  = addr;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("send_wait_bound", n < 200, 1'b1);
    t = cyc;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  bit soak_on = 1'b0;
  always @(negedge clk)
    if (soak_on) rsp_ready = ($urandom_range(0, 3) != 0);

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t0, t1, t2, nrsp;
    int tf[5];
    rstn      = 1'b0;
    req_valid = 1'b0;
    req_id    = '0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_occ", occ_o, 3'd0);
    check("rst_ready", req_ready, 1'b1);
    rstn = 1'b1;
    @(negedge clk);

    // Single request, L=5: response 7 cycles after the handshake cycle.
    send(4'd3, 32'h0000_0014, t);
    wait_cyc(t + 1);
    check("single_occ1", occ_o, 3'd1);
    wait_cyc(t + 6);
    check("single_early", rsp_valid, 1'b0);
    wait_cyc(t + 7);
    check("single_valid", rsp_valid, 1'b1);
    check("single_id", rsp_id, 4'd3);
    check("single_data", rsp_data, 32'hA5A5_0014);
    check("single_occ0", occ_o, 3'd0);
    wait_cyc(t + 8);
    check("single_gone", rsp_valid, 1'b0);

    // Reorder: L=15, L=0, L=2 issued back to back.
    send(4'd0, 32'h0000_003C, t0);
    send(4'd1, 32'h0000_0000, t1);
    send(4'd2, 32'h0000_0008, t2);
    check("reorder_b2b", t2 - t0, 2);
    wait_cyc(t0 + 3);
    check("reorder_1", {rsp_valid, rsp_id, rsp_data}, {1'b1, 4'd1, 32'hA5A5_0000});
    wait_cyc(t0 + 6);
    check("reorder_2", {rsp_valid, rsp_id, rsp_data}, {1'b1, 4'd2, 32'hA5A5_0008});
    wait_cyc(t0 + 17);
    check("reorder_0", {rsp_valid, rsp_id, rsp_data}, {1'b1, 4'd0, 32'hA5A5_003C});
    wait_cyc(t0 + 19);

    // Full: five L=15 requests into four slots.
    for (int k = 0; k < 4; k++) send(4'(k + 4), 32'h0000_003C | (k << 8), tf[k]);
    check("full_ready_low", req_ready, 1'b0);
    check("full_occ", occ_o, 3'd4);
    send(4'd8, 32'h0000_043C, tf[4]);
    check("full_b2b", tf[3] - tf[0], 3);
    check("full_5th_accept", tf[4] - tf[0], 17);
    wait_cyc(tf[4] + 19);
    check("full_drained", occ_o, 3'd0);

    // Backpressure: two L=0 requests with the consumer stalled for 10 cycles.
    rsp_ready = 1'b0;
    send(4'd7, 32'h0000_0100, t0);
    send(4'd8, 32'h0000_0200, t1);
    wait_cyc(t0 + 2);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {rsp_valid, rsp_id, rsp_data}, {1'b1, 4'd7, 32'hA5A5_0100});
      check("bp_occ", occ_o, 3'd1);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_second", {rsp_valid, rsp_id, rsp_data}, {1'b1, 4'd8, 32'hA5A5_0200});
    @(negedge clk);
    check("bp_done", {rsp_valid, occ_o}, {1'b0, 3'd0});

    // Reset mid-flight: three L=8 requests dropped, plus a request during reset.
    send(4'd9,  32'h0000_0020, t0);
    send(4'd10, 32'h0000_0060, t);
    send(4'd11, 32'h0000_00A0, t);
    wait_cyc(t0 + 4);
    rstn      = 1'b0;
    req_valid = 1'b1;
    req_id    = 4'd12;
    req_addr  = 32'h0000_0000;
    #1;
    check("midrst_valid", rsp_valid, 1'b0);
    check("midrst_occ", occ_o, 3'd0);
    check("midrst_ready", req_ready, 1'b1);
    repeat (2) @(negedge clk);
    rstn      = 1'b1;
    req_valid = 1'b0;
    nrsp = 0;
    repeat (25) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    check("midrst_no_rsp", nrsp, 0);
    send(4'd13, 32'h0000_000C, t);
    wait_cyc(t + 5);
    check("postrst_rsp", {rsp_valid, rsp_id, rsp_data}, {1'b1, 4'd13, 32'hA5A5_000C});
    wait_cyc(t + 7);

    // Random soak with a random consumer duty cycle.
    soak_on = 1'b1;
    for (int n = 0; n < 10000; n++)
      send(4'($urandom_range(0, 15)), $urandom, t);
    soak_on = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    repeat (40) @(negedge clk);
    check("soak_sb_empty", sb.size(), 0);
    check("soak_occ_final", occ_o, 3'd0);
    check("soak_valid_final", rsp_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
